// File: rtl/image_xfer_pkg.sv
// Shared opcodes, state encoding and status-byte layout for the image transfer controller.
// Pure declarations; no timing or flow control of its own.
package image_xfer_pkg;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_RUN   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SIZE = 3'd1,
      ST_WR   = 3'd2,
      ST_RD   = 3'd3,
      ST_RUN  = 3'd4,
      ST_CKR  = 3'd5,
      ST_CKT  = 3'd6
   } state_t;

   localparam int ERR_OVF_BIT = 0;
   localparam int ERR_CK_BIT  = 1;
   localparam int ERR_CMD_BIT = 2;

   localparam logic [7:0] RUN_STATUS = 8'h10;

   function automatic logic [7:0] status_byte(input state_t st, input logic [2:0] sticky);
      return {1'b0, st, 1'b0, sticky};
   endfunction

endpackage

// File: rtl/xfer_checksum.sv
// 8-bit XOR accumulator with synchronous clear (clear wins over enable).
// Result visible one clk after the enabling edge; no flow control.
module xfer_checksum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] acc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= 8'h00;
      end else if (en) begin
         acc <= acc ^ din;
      end
   end

endmodule

// File: rtl/image_transfer_controller.sv
// SPI-side image transfer controller: command decode, geometry, BRAM stream, PDI launch; XFER_CHECKSUM_EN adds CKR/CKT.
// All outputs registered, updated on the spi_cycle_done edge (RUN exit on pdi_done); no backpressure, spi_slave paces bytes.
module image_transfer_controller
   import image_xfer_pkg::*;
#(
   parameter int ADDR_W     = 17,
   parameter int MAX_PIXELS = 76800,
   parameter int NUM_CH     = 3,
   parameter int DIM_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cycle_done,
   input  logic [7:0]        spi_byte_in,
   output logic [7:0]        spi_byte_out,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [1:0]        bram_channel,
   output logic              bram_we,
   output logic [7:0]        bram_data_in,
   input  logic [7:0]        bram_data_out,
   output logic              pdi_active,
   input  logic              pdi_done,
   output logic              err
);

   localparam int GW         = 2 * DIM_W;
   localparam int CW         = (GW > ADDR_W + 1) ? GW : ADDR_W + 1;
   localparam int SIZE_BYTES = GW / 8;

   localparam logic [CW-1:0]     MAX_C     = CW'(MAX_PIXELS);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_PIXELS - 1);
   localparam logic [1:0]        CH_LAST   = 2'(NUM_CH);
   localparam logic [2:0]        SIZE_LAST = 3'(SIZE_BYTES - 1);

`ifdef XFER_CHECKSUM_EN
   localparam state_t WR_EXIT = ST_CKR;
   localparam state_t RD_EXIT = ST_CKT;
`else
   localparam state_t WR_EXIT = ST_IDLE;
   localparam state_t RD_EXIT = ST_IDLE;
`endif

   state_t            state, state_nxt;
   logic [GW-1:0]     geom, geom_nxt;
   logic [2:0]        size_idx, size_idx_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [CW-1:0]     idx, idx_nxt;
   logic [2:0]        sticky, sticky_nxt;
   logic [7:0]        sbo_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [1:0]        ch_nxt;
   logic              we_nxt;
   logic [7:0]        wdat_nxt;
   logic              pdi_nxt;

   logic [1:0]        cmd_op, cmd_ch;
   logic [GW-1:0]     geom_shift, mul_src, prod;
   logic [CW-1:0]     prod_c, rd_len, idx_inc;

   assign cmd_op = spi_byte_in[3:2];
   assign cmd_ch = spi_byte_in[1:0];

   // One multiplier: fed the incoming geometry while in SIZE, the stored geometry otherwise.
   assign geom_shift = {geom[GW-9:0], spi_byte_in};
   assign mul_src    = (state == ST_SIZE) ? geom_shift : geom;
   assign prod       = GW'(mul_src[GW-1:DIM_W]) * GW'(mul_src[DIM_W-1:0]);
   assign prod_c     = CW'(prod);
   assign rd_len     = (prod_c == '0 || prod_c > MAX_C) ? MAX_C : prod_c;
   assign idx_inc    = idx + CW'(1);

   assign err = |sticky;

`ifdef XFER_CHECKSUM_EN
   logic       ck_clr, ck_en;
   logic [7:0] ck_din, ck_acc;

   assign ck_clr = spi_cycle_done && (state == ST_IDLE);
   assign ck_en  = spi_cycle_done && (state == ST_WR || state == ST_RD);
   assign ck_din = (state == ST_RD) ? bram_data_out : spi_byte_in;

   xfer_checksum u_checksum (
      .clk (clk),
      .rst (rst),
      .clr (ck_clr),
      .en  (ck_en),
      .din (ck_din),
      .acc (ck_acc)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         geom         <= '0;
         size_idx     <= '0;
         cnt          <= '0;
         idx          <= '0;
         sticky       <= '0;
         spi_byte_out <= '0;
         bram_addr    <= '0;
         bram_channel <= '0;
         bram_we      <= 1'b0;
         bram_data_in <= '0;
         pdi_active   <= 1'b0;
      end else begin
         state        <= state_nxt;
         geom         <= geom_nxt;
         size_idx     <= size_idx_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         sticky       <= sticky_nxt;
         spi_byte_out <= sbo_nxt;
         bram_addr    <= addr_nxt;
         bram_channel <= ch_nxt;
         bram_we      <= we_nxt;
         bram_data_in <= wdat_nxt;
         pdi_active   <= pdi_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      geom_nxt     = geom;
      size_idx_nxt = size_idx;
      cnt_nxt      = cnt;
      idx_nxt      = idx;
      sticky_nxt   = sticky;
      sbo_nxt      = spi_byte_out;
      addr_nxt     = bram_addr;
      ch_nxt       = bram_channel;
      we_nxt       = 1'b0;
      wdat_nxt     = bram_data_in;
      pdi_nxt      = pdi_active;

      unique case (state)
         ST_IDLE: begin
            if (spi_cycle_done) begin
               unique case (cmd_op)
                  OP_WRITE, OP_READ: begin
                     if (cmd_ch == 2'd0 || cmd_ch > CH_LAST) begin
                        sticky_nxt[ERR_CMD_BIT] = 1'b1;
                     end else begin
                        ch_nxt = cmd_ch;
                        if (cmd_op == OP_WRITE) begin
                           state_nxt    = ST_SIZE;
                           size_idx_nxt = '0;
                        end else begin
                           state_nxt = ST_RD;
                           addr_nxt  = '0;
                           idx_nxt   = '0;
                           cnt_nxt   = rd_len;
                        end
                     end
                  end
                  OP_RUN: begin
                     state_nxt = ST_RUN;
                     pdi_nxt   = 1'b1;
                     sbo_nxt   = RUN_STATUS;
                  end
                  default: begin
                     if (cmd_ch == 2'd0) begin
                        sbo_nxt    = status_byte(state, sticky);
                        sticky_nxt = '0;
                     end
                  end
               endcase
            end
         end

         ST_SIZE: begin
            if (spi_cycle_done) begin
               geom_nxt     = geom_shift;
               size_idx_nxt = size_idx + 3'd1;
               if (size_idx == SIZE_LAST) begin
                  cnt_nxt = prod_c;
                  idx_nxt = '0;
                  if (prod_c == '0) begin
                     state_nxt = ST_IDLE;
                  end else begin
                     state_nxt = ST_WR;
                     if (prod_c > MAX_C) begin
                        sticky_nxt[ERR_OVF_BIT] = 1'b1;
                     end
                  end
               end
            end
         end

         ST_WR: begin
            if (spi_cycle_done) begin
               wdat_nxt = spi_byte_in;
               // Bytes past the BRAM depth are swallowed; address holds at the last written pixel.
               if (idx < MAX_C) begin
                  we_nxt   = 1'b1;
                  addr_nxt = idx[ADDR_W-1:0];
               end
               idx_nxt = idx_inc;
               if (idx_inc == cnt) begin
                  state_nxt = WR_EXIT;
               end
            end
         end

         ST_RD: begin
            if (spi_cycle_done) begin
               sbo_nxt = bram_data_out;
               if (bram_addr < ADDR_LAST) begin
                  addr_nxt = bram_addr + ADDR_W'(1);
               end
               idx_nxt = idx_inc;
               if (idx_inc == cnt) begin
                  state_nxt = RD_EXIT;
               end
            end
         end

         ST_RUN: begin
            // pdi_done takes priority; a coincident SPI byte is dropped.
            if (pdi_done) begin
               pdi_nxt   = 1'b0;
               state_nxt = ST_IDLE;
            end else if (spi_cycle_done) begin
               sbo_nxt = RUN_STATUS;
            end
         end

`ifdef XFER_CHECKSUM_EN
         ST_CKR: begin
            if (spi_cycle_done) begin
               if (spi_byte_in != ck_acc) begin
                  sticky_nxt[ERR_CK_BIT] = 1'b1;
               end
               state_nxt = ST_IDLE;
            end
         end

         ST_CKT: begin
            if (spi_cycle_done) begin
               sbo_nxt   = ck_acc;
               state_nxt = ST_IDLE;
            end
         end
`endif

         default: begin
            state_nxt    = ST_IDLE;
            geom_nxt     = '0;
            size_idx_nxt = '0;
            cnt_nxt      = '0;
            idx_nxt      = '0;
            sticky_nxt   = '0;
            sbo_nxt      = '0;
            addr_nxt     = '0;
            ch_nxt       = '0;
            wdat_nxt     = '0;
            pdi_nxt      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_image_transfer_controller.sv
// Directed bench for image_transfer_controller with a small BRAM model (MAX_PIXELS reduced to 16).
// Works in both builds; the checksum-specific steps are guarded by XFER_CHECKSUM_EN.
module tb_image_transfer_controller;

   localparam int ADDR_W = 17;
   localparam int MAXP   = 16;
   localparam int NUM_CH = 3;
   localparam int DIM_W  = 16;
   localparam int AW_TB  = $clog2(MAXP);

   logic              clk = 1'b0;
   logic              rst;
   logic              spi_cycle_done;
   logic [7:0]        spi_byte_in;
   logic [7:0]        spi_byte_out;
   logic [ADDR_W-1:0] bram_addr;
   logic [1:0]        bram_channel;
   logic              bram_we;
   logic [7:0]        bram_data_in;
   logic [7:0]        bram_data_out;
   logic              pdi_active;
   logic              pdi_done;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   image_transfer_controller #(
      .ADDR_W     (ADDR_W),
      .MAX_PIXELS (MAXP),
      .NUM_CH     (NUM_CH),
      .DIM_W      (DIM_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .spi_cycle_done (spi_cycle_done),
      .spi_byte_in    (spi_byte_in),
      .spi_byte_out   (spi_byte_out),
      .bram_addr      (bram_addr),
      .bram_channel   (bram_channel),
      .bram_we        (bram_we),
      .bram_data_in   (bram_data_in),
      .bram_data_out  (bram_data_out),
      .pdi_active     (pdi_active),
      .pdi_done       (pdi_done),
      .err            (err)
   );

   logic [7:0] mem [4][MAXP] = '{default: 8'hEE};

   always @(posedge clk) begin
      if (bram_we) mem[bram_channel][bram_addr[AW_TB-1:0]] <= bram_data_in;
      bram_data_out <= mem[bram_channel][bram_addr[AW_TB-1:0]];
   end

   logic [ADDR_W-1:0] wr_addr_q [$];
   logic [7:0]        wr_dat_q  [$];
   logic [1:0]        wr_ch_q   [$];

   always @(negedge clk) begin
      if (bram_we === 1'b1) begin
         wr_addr_q.push_back(bram_addr);
         wr_dat_q.push_back(bram_data_in);
         wr_ch_q.push_back(bram_channel);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic [7:0] so);
      @(negedge clk);
      spi_byte_in    = b;
      spi_cycle_done = 1'b1;
      @(negedge clk);
      spi_cycle_done = 1'b0;
      so             = spi_byte_out;
      @(negedge clk);
   endtask

   task automatic send_size(input logic [15:0] h, input logic [15:0] w);
      logic [7:0] so;
      send_byte(h[15:8], so);
      send_byte(h[7:0], so);
      send_byte(w[15:8], so);
      send_byte(w[7:0], so);
   endtask

   initial begin
      logic [7:0] so;
      logic [7:0] exp_rd [16];
      int base;

      rst            = 1'b1;
      spi_cycle_done = 1'b0;
      spi_byte_in    = 8'h00;
      pdi_done       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check_eq("rst_byte_out", spi_byte_out, 0);
      check_eq("rst_addr", bram_addr, 0);
      check_eq("rst_channel", bram_channel, 0);
      check_eq("rst_we", bram_we, 0);
      check_eq("rst_data_in", bram_data_in, 0);
      check_eq("rst_pdi", pdi_active, 0);
      check_eq("rst_err", err, 0);

      // write 2x3 to channel 1
      base = wr_addr_q.size();
      send_byte(8'h05, so);
      send_size(16'd2, 16'd3);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), so);
`ifdef XFER_CHECKSUM_EN
      send_byte(8'h01, so);
`endif
      check_eq("wr_count", wr_addr_q.size() - base, 6);
      for (int i = 0; i < 6; i++) begin
         check_eq($sformatf("wr_addr%0d", i), wr_addr_q[base+i], i);
         check_eq($sformatf("wr_dat%0d", i), wr_dat_q[base+i], 8'h10 + i);
         check_eq($sformatf("wr_ch%0d", i), wr_ch_q[base+i], 1);
      end
      check_eq("wr_err", err, 0);

      // read back channel 1
      base = wr_addr_q.size();
      send_byte(8'h09, so);
      for (int i = 0; i < 6; i++) begin
         send_byte(8'h00, so);
         check_eq($sformatf("rd%0d", i), so, 8'h10 + i);
      end
`ifdef XFER_CHECKSUM_EN
      send_byte(8'h00, so);
      check_eq("rd_cksum", so, 8'h01);
`endif
      send_byte(8'h00, so);
      check_eq("rd_idle_status", so, 8'h00);
      check_eq("rd_no_write", wr_addr_q.size() - base, 0);

      // invalid channel on a write
      send_byte(8'h04, so);
      check_eq("badch_err", err, 1);
      send_byte(8'h00, so);
      check_eq("badch_status1", so, 8'h04);
      check_eq("badch_err_clr", err, 0);
      send_byte(8'h00, so);
      check_eq("badch_status2", so, 8'h00);

      // overflow: 4x6 = 24 bytes into a 16-deep channel 2
      base = wr_addr_q.size();
      send_byte(8'h06, so);
      send_size(16'd4, 16'd6);
      check_eq("ovf_err", err, 1);
      for (int i = 0; i < 24; i++) send_byte(8'(8'h40 + i), so);
`ifdef XFER_CHECKSUM_EN
      send_byte(8'h00, so);
`endif
      check_eq("ovf_count", wr_addr_q.size() - base, 16);
      check_eq("ovf_first_addr", wr_addr_q[base], 0);
      check_eq("ovf_last_addr", wr_addr_q[base+15], 15);
      check_eq("ovf_last_dat", wr_dat_q[base+15], 8'h4F);
      check_eq("ovf_ch", wr_ch_q[base+15], 2);
      send_byte(8'h00, so);
      check_eq("ovf_status1", so, 8'h01);
      send_byte(8'h00, so);
      check_eq("ovf_status2", so, 8'h00);

      // read channel 2: geometry 24 clamps to 16 bytes
      send_byte(8'h0A, so);
      for (int i = 0; i < 16; i++) begin
         send_byte(8'h00, so);
         check_eq($sformatf("rdovf%0d", i), so, 8'h40 + i);
      end
`ifdef XFER_CHECKSUM_EN
      send_byte(8'h00, so);
      check_eq("rdovf_cksum", so, 8'h00);
`endif
      send_byte(8'h00, so);
      check_eq("rdovf_idle_status", so, 8'h00);

      // PDI run with pdi_done colliding with an SPI byte
      base = wr_addr_q.size();
      send_byte(8'h0C, so);
      check_eq("run_byte0", so, 8'h10);
      check_eq("run_active", pdi_active, 1);
      send_byte(8'hFF, so);
      check_eq("run_byte1", so, 8'h10);
      @(negedge clk);
      spi_byte_in    = 8'h05;
      spi_cycle_done = 1'b1;
      pdi_done       = 1'b1;
      @(negedge clk);
      spi_cycle_done = 1'b0;
      pdi_done       = 1'b0;
      check_eq("run_exit_pdi", pdi_active, 0);
      @(negedge clk);
      send_byte(8'h00, so);
      check_eq("run_exit_status", so, 8'h00);
      check_eq("run_no_write", wr_addr_q.size() - base, 0);

`ifdef XFER_CHECKSUM_EN
      send_byte(8'h07, so);
      send_size(16'd1, 16'd2);
      send_byte(8'hA5, so);
      send_byte(8'h0F, so);
      send_byte(8'hAA, so);
      send_byte(8'h00, so);
      check_eq("ck_good_status", so, 8'h00);
      send_byte(8'h07, so);
      send_size(16'd1, 16'd2);
      send_byte(8'hA5, so);
      send_byte(8'h0F, so);
      send_byte(8'h00, so);
      check_eq("ck_bad_err", err, 1);
      send_byte(8'h00, so);
      check_eq("ck_bad_status", so, 8'h02);
`endif

      // reset in the middle of a 2x3 write to channel 1
      send_byte(8'h05, so);
      send_size(16'd2, 16'd3);
      send_byte(8'h81, so);
      send_byte(8'h82, so);
      send_byte(8'h83, so);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("mrst_byte_out", spi_byte_out, 0);
      check_eq("mrst_addr", bram_addr, 0);
      check_eq("mrst_channel", bram_channel, 0);
      check_eq("mrst_we", bram_we, 0);
      check_eq("mrst_data_in", bram_data_in, 0);
      check_eq("mrst_pdi", pdi_active, 0);
      check_eq("mrst_err", err, 0);
      base = wr_addr_q.size();
      send_byte(8'h91, so);
      send_byte(8'h92, so);
      send_byte(8'h93, so);
      check_eq("mrst_no_write", wr_addr_q.size() - base, 0);
      check_eq("mrst_err_after", err, 0);

      // geometry cleared by reset: read returns a full MAX_PIXELS channel
      exp_rd = '{8'h81, 8'h82, 8'h83, 8'h13, 8'h14, 8'h15,
                 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
      send_byte(8'h09, so);
      for (int i = 0; i < 16; i++) begin
         send_byte(8'h00, so);
         check_eq($sformatf("rdzero%0d", i), so, exp_rd[i]);
      end
`ifdef XFER_CHECKSUM_EN
      send_byte(8'h00, so);
`endif
      send_byte(8'h00, so);
      check_eq("rdzero_idle_status", so, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
